// File: rtl/bitcheck_pkg.sv
// rtl/bitcheck_pkg.sv - shared state encoding and sizing helper for bitcheck
package bitcheck_pkg;

   // Encodings are fixed so external probes can decode the state register
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Timer width: enough to hold max(a,b)-1, never narrower than one bit
   function automatic int cnt_width(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/bitcheck_contador_dn.sv
// rtl/bitcheck_contador_dn.sv - loadable down-counter with zero flag
module contador_dn #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   // Load has priority over decrement; the caller stops decrementing at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/bitcheck.sv
// rtl/bitcheck.sv - on-chip level checker with settle and check windows
module bitcheck
   import bitcheck_pkg::*;
#(
   parameter logic VALOR    = 1'b1,
   parameter int   N_SETTLE = 10,
   parameter int   N_CHECK  = 16,
   parameter int   CW       = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          entrada,
   output logic          busy,
   output logic          done,
   output logic          ok,
   output logic          fail,
   output logic [CW-1:0] err_count
);

   localparam int            TW        = cnt_width(N_SETTLE, N_CHECK);
   localparam logic [TW-1:0] SETTLE_LD = TW'(N_SETTLE - 1);
   localparam logic [TW-1:0] CHECK_LD  = TW'(N_CHECK - 1);
   localparam logic [CW-1:0] ERR_MAX   = '1;

   state_t        r_state;
   logic          r_entrada;
   logic          w_load;
   logic [TW-1:0] w_load_val;
   logic          w_dec;
   logic          w_zero;
   logic [CW-1:0] w_err_next;

   // Same-domain on-chip source: one register stage, no synchronizer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_entrada <= 1'b0;
      end else begin
         r_entrada <= entrada;
      end
   end

   // Timer control: load settle length on start, check length at end of settle
   always_comb begin
      w_load     = 1'b0;
      w_load_val = CHECK_LD;
      w_dec      = 1'b0;
      if (r_state == ST_IDLE) begin
         w_load     = start;
         w_load_val = SETTLE_LD;
      end else if (r_state == ST_SETTLE && w_zero) begin
         w_load = 1'b1;
      end else if ((r_state == ST_SETTLE || r_state == ST_CHECK) && !w_zero) begin
         w_dec = 1'b1;
      end
   end

   contador_dn #(
      .W (TW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   // Saturating mismatch count for this cycle's compare
   always_comb begin
      w_err_next = err_count;
      if ((r_entrada != VALOR) && (err_count != ERR_MAX)) begin
         w_err_next = err_count + CW'(1);
      end
   end

   // Run sequencer; ok/fail use the updated count so the last compare is included
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         ok        <= 1'b0;
         fail      <= 1'b0;
         err_count <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_SETTLE;
                  busy      <= 1'b1;
                  ok        <= 1'b0;
                  fail      <= 1'b0;
                  err_count <= '0;
               end
            end
            ST_SETTLE: begin
               if (w_zero) begin
                  r_state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               err_count <= w_err_next;
               if (w_zero) begin
                  r_state <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  ok      <= (w_err_next == '0);
                  fail    <= (w_err_next != '0);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitcheck.sv
// tb/tb_bitcheck.sv - randomized scoreboard bench for bitcheck
module tb_bitcheck;

   localparam int NS    = 10;
   localparam int NC    = 16;
   localparam int EMAX  = 255;
   localparam int HSIZE = 8192;

   typedef struct {
      int err;
      bit ok;
      bit fail;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       entrada = 1'b0;
   logic       busy, done, ok, fail;
   logic [7:0] err_count;

   logic       start2 = 1'b0;
   logic       entrada2 = 1'b0;
   logic       busy2, done2, ok2, fail2;
   logic [7:0] err_count2;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int   cyc = 0;
   logic hist [0:HSIZE-1];
   bit   active = 0;
   int   m_st = 0;
   int   m_done = 0;
   int   last_err = 0;
   bit   last_ok = 0;
   bit   last_fail = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   bitcheck #(.VALOR(1'b1), .N_SETTLE(NS), .N_CHECK(NC), .CW(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .entrada(entrada),
      .busy(busy), .done(done), .ok(ok), .fail(fail), .err_count(err_count)
   );

   bitcheck #(.VALOR(1'b1), .N_SETTLE(NS), .N_CHECK(300), .CW(8)) u_long (
      .clk(clk), .rst(rst), .start(start2), .entrada(entrada2),
      .busy(busy2), .done(done2), .ok(ok2), .fail(fail2), .err_count(err_count2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a run started at edge s compares the samples taken at edges
   // s+NS .. s+NS+NC-1 and reports at edge s+NS+NC; the edge after that
   // returns to idle, so the earliest next start is two edges after the report.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         active    = 0;
         exp_q.delete();
         last_err  = 0;
         last_ok   = 0;
         last_fail = 0;
      end else begin
         exp_t e;
         int   n;
         cyc++;
         if (cyc < HSIZE) hist[cyc] = entrada;
         if (active) begin
            if (cyc == m_done) begin
               n = 0;
               for (int k = m_st + NS; k < m_st + NS + NC; k++)
                  if (hist[k] !== 1'b1) n++;
               if (n > EMAX) n = EMAX;
               e.err = n; e.ok = (n == 0); e.fail = (n != 0); e.cyc = cyc;
               exp_q.push_back(e);
               last_err = n; last_ok = (n == 0); last_fail = (n != 0);
            end else if (cyc == m_done + 1) begin
               active = 0;
            end
         end else if (start) begin
            active    = 1;
            m_st      = cyc;
            m_done    = cyc + NS + NC;
            last_err  = 0;
            last_ok   = 0;
            last_fail = 0;
         end
      end
   end

   // Monitor: pops an expectation whenever the DUT pulses done
   always @(negedge clk) begin
      bit exp_busy;
      bit exp_done;
      exp_t e;
      exp_busy = active && (cyc < m_done);
      exp_done = active && (cyc == m_done);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("ok_and_fail_exclusive", ok & fail, 0);
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("run_err_count", err_count, e.err);
            chk("run_ok", ok, e.ok);
            chk("run_fail", fail, e.fail);
            chk("run_done_cycle", cyc, e.cyc);
         end
      end
      if (!exp_busy) begin
         chk("held_err_count", err_count, last_err);
         chk("held_ok", ok, last_ok);
         chk("held_fail", fail, last_fail);
      end
   end

   task automatic drive(input bit s, input bit e);
      @(negedge clk);
      start   = s;
      entrada = e;
   endtask

   task automatic run_pulse(input bit e, input int cycles);
      drive(1, e);
      repeat (cycles - 1) drive(0, e);
   endtask

   initial begin
      int k;
      int gap;
      int slen;
      int rlen;
      int mode;

      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ok", ok, 0);
      chk("reset_fail", fail, 0);
      chk("reset_err", err_count, 0);
      rst = 1'b0;
      repeat (2) drive(0, 1);

      // constant good line
      run_pulse(1, 32);
      chk("t1_ok", ok, 1);
      chk("t1_err", err_count, 0);

      // constant bad line
      run_pulse(0, 32);
      chk("t2_fail", fail, 1);
      chk("t2_err", err_count, NC);

      // glitch confined to the settle window
      drive(1, 1);
      repeat (8) drive(0, 0);
      repeat (25) drive(0, 1);
      chk("t3a_ok", ok, 1);
      chk("t3a_err", err_count, 0);

      // three-cycle glitch inside the check window
      drive(1, 1);
      repeat (12) drive(0, 1);
      repeat (3) drive(0, 0);
      repeat (20) drive(0, 1);
      chk("t3b_fail", fail, 1);
      chk("t3b_err", err_count, 3);

      // asynchronous reset in the middle of a failing run
      drive(1, 0);
      repeat (14) drive(0, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t4_busy_after_rst", busy, 0);
      chk("t4_done_after_rst", done, 0);
      chk("t4_ok_after_rst", ok, 0);
      chk("t4_fail_after_rst", fail, 0);
      chk("t4_err_after_rst", err_count, 0);
      #1 rst = 1'b0;
      repeat (2) drive(0, 1);
      run_pulse(1, 30);
      chk("t4_rerun_ok", ok, 1);

      // start held high: back-to-back runs
      repeat (60) drive(1, 1);
      repeat (30) drive(0, 1);

      // second start during busy is ignored
      drive(1, 1);
      repeat (4) drive(0, 1);
      drive(1, 1);
      repeat (30) drive(0, 1);

      // randomized runs, with stray start pulses during runs
      repeat (25) begin
         gap  = $urandom_range(0, 5);
         slen = $urandom_range(1, 3);
         rlen = $urandom_range(20, 35);
         mode = $urandom_range(0, 3);
         repeat (gap) drive(0, $urandom_range(0, 1));
         repeat (slen) drive(1, ($urandom_range(0, 7) != 0));
         repeat (rlen) begin
            if (mode == 0) drive(($urandom_range(0, 15) == 0), 1'b0);
            else if (mode == 1) drive(($urandom_range(0, 15) == 0), 1'b1);
            else drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0));
         end
      end
      repeat (35) drive(0, 1);

      // long check window saturates the counter
      @(negedge clk);
      start2   = 1'b1;
      entrada2 = 1'b0;
      @(negedge clk);
      start2 = 1'b0;
      k = 0;
      while (k < 400) begin
         @(negedge clk);
         k++;
         if (done2) break;
      end
      chk("t6_done_latency", k, 310);
      chk("t6_err_saturated", err_count2, EMAX);
      chk("t6_fail", fail2, 1);
      chk("t6_ok", ok2, 0);
      chk("t6_busy", busy2, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("model_idle", active, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
